stall_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order CPU core. It combines per-stage stall requests, branch-outstanding tracking and redirect flushes into per-stage stall, bubble and flush controls, from the PC register (stage 0) to the last pipe register. It generalises the single IF/branch staller to N stages and up to MAX_PENDING unresolved branches. It replaces the inferred latch with a registered pending counter, and adds flush priority, error detection and a stall-cycle performance counter.

---
 rtl/stall_ctrl_pkg.sv | 30 +++
 rtl/stall_ctrl_if.sv | 39 +++
 rtl/stall_ctrl_br_pending_ctr.sv | 54 +++++
 rtl/stall_ctrl.sv | 99 +++++++++
 tb/tb_stall_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - stage index constants for the five-register in-order pipe
//   - width helpers for the stage index and the pending-branch counter
//   - saturating increment used by the stall-cycle performance counter
package stall_ctrl_pkg;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;

    // Width of a stage index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned num_stages);
        return (num_stages > 1) ? int'($clog2(num_stages)) : 1;
    endfunction

    // Width able to hold 0..max_pending inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_pending);
        return (max_pending > 0) ? int'($clog2(max_pending + 1)) : 1;
    endfunction

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard-control bundle between the pipeline and stall_ctrl.
//   master: the pipeline side; drives requests/branch events, receives controls.
//   slave : stall_ctrl; receives requests, drives stall/bubble/flush and status.
//   stall_req    stage i cannot advance        flush_req/flush_upto  redirect
//   br_issue     unresolved branch issued      br_resolve            oldest branch done
//   stall/bubble/flush  per-stage controls     br_pending/br_err/stall_cycles  status
interface stall_ctrl_if
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned MAX_PENDING = 1,
    parameter int unsigned PERF_W      = 32
);
    localparam int unsigned IDX_W = idx_w(NUM_STAGES);
    localparam int unsigned CNT_W = cnt_w(MAX_PENDING);

    logic [NUM_STAGES-1:0] stall_req;
    logic                  br_issue;
    logic                  br_resolve;
    logic                  flush_req;
    logic [IDX_W-1:0]      flush_upto;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] flush;
    logic [CNT_W-1:0]      br_pending;
    logic                  br_err;
    logic [PERF_W-1:0]     stall_cycles;

    modport master (
        output stall_req, br_issue, br_resolve, flush_req, flush_upto,
        input  stall, bubble, flush, br_pending, br_err, stall_cycles
    );

    modport slave (
        input  stall_req, br_issue, br_resolve, flush_req, flush_upto,
        output stall, bubble, flush, br_pending, br_err, stall_cycles
    );

endinterface

// File: rtl/stall_ctrl_br_pending_ctr.sv
// stall_ctrl_br_pending_ctr: tracks unresolved branches in flight.
//   clk, rst     clock, synchronous active-high reset
//   br_issue     branch issued (accepted unless full without a same-cycle resolve)
//   br_resolve   oldest branch resolved (ignored when nothing is pending)
//   flush_req    redirect; drops every pending branch, including one issued now
//   br_pending   registered count of unresolved branches
//   br_full      effective count (this cycle's accepted events applied) is at the limit
//   br_err       sticky: set by a rejected issue or a resolve with nothing pending
module stall_ctrl_br_pending_ctr
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 1,
    parameter int unsigned CNT_W       = cnt_w(MAX_PENDING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_issue,
    input  logic             br_resolve,
    input  logic             flush_req,
    output logic [CNT_W-1:0] br_pending,
    output logic             br_full,
    output logic             br_err
);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0] cnt_q, cnt_d, eff;
    logic             err_q, err_d;
    logic             at_max, acc_issue, acc_resolve;

    always_comb begin
        at_max      = (cnt_q == MaxCnt);
        // A same-cycle resolve frees a slot, so issue is taken even when full.
        acc_issue   = br_issue && !(at_max && !br_resolve);
        acc_resolve = br_resolve && (cnt_q != '0);
        eff         = cnt_q + CNT_W'(acc_issue) - CNT_W'(acc_resolve);
        br_full     = (eff == MaxCnt);
        cnt_d       = flush_req ? '0 : eff;
        err_d       = err_q | (br_issue & ~acc_issue) | (br_resolve & ~acc_resolve);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign br_pending = cnt_q;
    assign br_err     = err_q;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: per-stage stall/bubble/flush generation for the in-order pipe.
//   clk, rst   clock, synchronous active-high reset
//   bus        stall_ctrl_if slave: stage stall requests, branch issue/resolve,
//              redirect flush in; stall/bubble/flush, br_pending, br_err and the
//              saturating stall_cycles counter out.
// Stage 0 is the PC register; higher indices are later pipe registers. A stall
// at stage i holds every earlier stage too; the branch stall holds the front
// stages while the pending-branch limit is reached. flush > stall > bubble.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned FRONT_STAGES = 2,
    parameter int unsigned MAX_PENDING  = 1,
    parameter int unsigned PERF_W       = 32
) (
    input logic         clk,
    input logic         rst,
    stall_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = cnt_w(MAX_PENDING);

    logic                  br_full;
    logic                  br_hold;
    logic [CNT_W-1:0]      br_pending;
    logic                  br_err;
    logic [NUM_STAGES-1:0] any_req;
    logic [NUM_STAGES-1:0] flush_vec, stall_vec, bubble_vec;
    logic [PERF_W-1:0]     cyc_q, cyc_d;

    stall_ctrl_br_pending_ctr #(
        .MAX_PENDING(MAX_PENDING),
        .CNT_W      (CNT_W)
    ) u_br_ctr (
        .clk       (clk),
        .rst       (rst),
        .br_issue  (bus.br_issue),
        .br_resolve(bus.br_resolve),
        .flush_req (bus.flush_req),
        .br_pending(br_pending),
        .br_full   (br_full),
        .br_err    (br_err)
    );

    // any_req[i]: some stage at or after i is blocked, so i cannot advance.
    always_comb begin
        any_req = '0;
        any_req[NUM_STAGES-1] = bus.stall_req[NUM_STAGES-1];
        for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
            any_req[i] = bus.stall_req[i] | any_req[i+1];
        end
    end

    // A redirect kills the branch stall everywhere, not just in flushed stages.
    assign br_hold = br_full && !bus.flush_req;

    always_comb begin
        flush_vec  = '0;
        stall_vec  = '0;
        bubble_vec = '0;
        if (!rst) begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                // Indices beyond the last stage simply cover every stage.
                flush_vec[i] = bus.flush_req && (i <= int'(bus.flush_upto));
            end
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                stall_vec[i] = !flush_vec[i] &&
                               (any_req[i] || ((i < int'(FRONT_STAGES)) && br_hold));
            end
            // The PC register (stage 0) never takes a bubble.
            for (int i = 1; i < int'(NUM_STAGES); i++) begin
                bubble_vec[i] = !flush_vec[i] && stall_vec[i-1] && !stall_vec[i];
            end
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        if (stall_vec[STG_PC]) begin
            cyc_d = PERF_W'(sat_inc(64'(cyc_q), PERF_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.stall        = stall_vec;
    assign bus.bubble       = bubble_vec;
    assign bus.flush        = flush_vec;
    assign bus.br_pending   = br_pending;
    assign bus.br_err       = br_err;
    assign bus.stall_cycles = cyc_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed-vector bench for stall_ctrl with a scoreboard.
// Three instances: A (defaults), B (MAX_PENDING=2), C (PERF_W=4).
// Stimulus pushes expected values tagged with the cycle they must appear in;
// a negedge monitor pops and compares whatever is due in the current cycle.
module tb_stall_ctrl;

    typedef enum int {SStall, SBubble, SFlush, SPend, SErr, SCyc} sig_e;

    typedef struct {
        int          stamp;
        int          dut;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    stall_ctrl_if #(.NUM_STAGES(5), .MAX_PENDING(1), .PERF_W(32)) if_a ();
    stall_ctrl_if #(.NUM_STAGES(5), .MAX_PENDING(2), .PERF_W(32)) if_b ();
    stall_ctrl_if #(.NUM_STAGES(5), .MAX_PENDING(1), .PERF_W(4))  if_c ();

    stall_ctrl #(.NUM_STAGES(5), .FRONT_STAGES(2), .MAX_PENDING(1), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    stall_ctrl #(.NUM_STAGES(5), .FRONT_STAGES(2), .MAX_PENDING(2), .PERF_W(32)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );
    stall_ctrl #(.NUM_STAGES(5), .FRONT_STAGES(2), .MAX_PENDING(1), .PERF_W(4)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [31:0] actual(input int d, input sig_e s);
        logic [4:0]  st, bb, fl;
        logic [31:0] pd, cy;
        logic        er;
        case (d)
            0: begin
                st = if_a.stall; bb = if_a.bubble; fl = if_a.flush;
                pd = 32'(if_a.br_pending); er = if_a.br_err; cy = if_a.stall_cycles;
            end
            1: begin
                st = if_b.stall; bb = if_b.bubble; fl = if_b.flush;
                pd = 32'(if_b.br_pending); er = if_b.br_err; cy = if_b.stall_cycles;
            end
            default: begin
                st = if_c.stall; bb = if_c.bubble; fl = if_c.flush;
                pd = 32'(if_c.br_pending); er = if_c.br_err; cy = 32'(if_c.stall_cycles);
            end
        endcase
        case (s)
            SStall:  return 32'(st);
            SBubble: return 32'(bb);
            SFlush:  return 32'(fl);
            SPend:   return pd;
            SErr:    return 32'(er);
            default: return cy;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].stamp <= cycle) begin
                logic [31:0] act;
                act = actual(sb[k].dut, sb[k].sig);
                checks++;
                if (sb[k].stamp < cycle || act !== sb[k].val) begin
                    errors++;
                    $display("FAIL %s (dut%0d cycle %0d): actual %0h required %0h",
                             sb[k].name, sb[k].dut, cycle, act, sb[k].val);
                end
                sb.delete(k);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (cycle %0d): actual %0h required %0h", n, cycle, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int d, input sig_e s, input logic [31:0] v, input string n,
                      input int dly = 0);
        exp_t e;
        e.stamp = cycle + dly;
        e.dut   = d;
        e.sig   = s;
        e.val   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    task automatic idle_a();
        if_a.stall_req = '0; if_a.br_issue = 1'b0; if_a.br_resolve = 1'b0;
        if_a.flush_req = 1'b0; if_a.flush_upto = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        if_b.stall_req = '0; if_b.br_issue = 1'b0; if_b.br_resolve = 1'b0;
        if_b.flush_req = 1'b0; if_b.flush_upto = '0;
        if_c.stall_req = '0; if_c.br_issue = 1'b0; if_c.br_resolve = 1'b0;
        if_c.flush_req = 1'b0; if_c.flush_upto = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1: make A busy (pending, error, stall cycles) then reset it.
        tick();
        if_a.br_issue = 1'b1; if_a.stall_req = 5'b00010;
        ex(0, SStall, 5'b00011, "pre_rst_stall");
        ex(0, SBubble, 5'b00100, "pre_rst_bubble");
        tick();
        ex(0, SPend, 1, "pre_rst_pend");
        ex(0, SErr, 1, "reject_issue_err", 1);
        tick();
        if_a.br_issue = 1'b0; rst = 1'b1; if_a.flush_req = 1'b1; if_a.flush_upto = 3'd4;
        ex(0, SStall, 0, "rst_stall");
        ex(0, SFlush, 0, "rst_flush");
        ex(0, SBubble, 0, "rst_bubble");
        ex(0, SCyc, 2, "pre_rst_cycles");
        #1;
        chk("rst_stall_direct", 32'(if_a.stall), 0);
        chk("rst_flush_direct", 32'(if_a.flush), 0);
        chk("rst_bubble_direct", 32'(if_a.bubble), 0);
        tick();
        rst = 1'b0; idle_a();
        ex(0, SPend, 0, "post_rst_pend");
        ex(0, SErr, 0, "post_rst_err");
        ex(0, SCyc, 0, "post_rst_cycles");
        #1;
        chk("post_rst_pend_direct", 32'(if_a.br_pending), 0);
        chk("post_rst_err_direct", 32'(if_a.br_err), 0);
        chk("post_rst_cycles_direct", if_a.stall_cycles, 0);

        // 2: single branch on A, resolved four cycles later.
        tick();
        if_a.br_issue = 1'b1;
        ex(0, SStall, 5'b00011, "br_issue_stall");
        ex(0, SPend, 0, "br_issue_pend");
        for (int i = 1; i <= 3; i++) begin
            tick();
            if_a.br_issue = 1'b0;
            ex(0, SStall, 5'b00011, "br_hold_stall");
            ex(0, SPend, 1, "br_hold_pend");
        end
        tick();
        if_a.br_resolve = 1'b1;
        ex(0, SStall, 0, "br_resolve_stall");
        ex(0, SPend, 1, "br_resolve_pend");
        ex(0, SCyc, 4, "br_cycles");
        tick();
        if_a.br_resolve = 1'b0;
        ex(0, SPend, 0, "br_done_pend");
        ex(0, SCyc, 4, "br_done_cycles");
        ex(0, SErr, 0, "br_done_err");

        // 3: backpressure patterns on A.
        tick();
        if_a.stall_req = 5'b01000;
        ex(0, SStall, 5'b01111, "exmem_stall");
        ex(0, SBubble, 5'b10000, "exmem_bubble");
        tick();
        if_a.stall_req = 5'b00010;
        ex(0, SStall, 5'b00011, "ifid_stall");
        ex(0, SBubble, 5'b00100, "ifid_bubble");
        tick();
        if_a.stall_req = 5'b10001;
        ex(0, SStall, 5'b11111, "all_stall");
        ex(0, SBubble, 5'b00000, "all_bubble");
        tick();
        if_a.stall_req = 5'b00001;
        ex(0, SStall, 5'b00001, "pc_stall");
        ex(0, SBubble, 5'b00010, "pc_bubble");

        // 4: flush interactions on A.
        tick();
        if_a.stall_req = '0; if_a.br_issue = 1'b1;
        ex(0, SStall, 5'b00011, "fl_a_issue_stall");
        tick();
        if_a.br_issue = 1'b0; if_a.flush_req = 1'b1; if_a.flush_upto = 3'd2;
        if_a.br_resolve = 1'b1;
        ex(0, SFlush, 5'b00111, "fl_a_flush");
        ex(0, SStall, 0, "fl_a_stall");
        ex(0, SBubble, 0, "fl_a_bubble");
        ex(0, SPend, 1, "fl_a_pend_now");
        ex(0, SPend, 0, "fl_a_pend_next", 1);
        tick();
        if_a.flush_req = 1'b0; if_a.br_resolve = 1'b0; if_a.flush_upto = '0;
        if_a.br_issue = 1'b1;
        ex(0, SStall, 5'b00011, "fl_b_issue_stall");
        tick();
        if_a.br_issue = 1'b0; if_a.flush_req = 1'b1; if_a.flush_upto = 3'd0;
        ex(0, SFlush, 5'b00001, "fl_b_flush");
        ex(0, SStall, 0, "fl_b_cancel_stall");
        ex(0, SBubble, 0, "fl_b_bubble");
        ex(0, SPend, 0, "fl_b_pend_next", 1);
        tick();
        if_a.br_issue = 1'b1; if_a.flush_upto = 3'd1; if_a.stall_req = 5'b01000;
        ex(0, SFlush, 5'b00011, "fl_c_flush");
        ex(0, SStall, 5'b01100, "fl_c_stall");
        ex(0, SBubble, 5'b10000, "fl_c_bubble");
        ex(0, SPend, 0, "fl_c_same_cycle_issue", 1);
        tick();
        if_a.br_issue = 1'b0; if_a.flush_upto = 3'd7;
        ex(0, SFlush, 5'b11111, "fl_d_sat_flush");
        ex(0, SStall, 0, "fl_d_stall");
        ex(0, SBubble, 0, "fl_d_bubble");
        tick();
        idle_a(); if_a.br_resolve = 1'b1;
        ex(0, SErr, 0, "idle_resolve_err_now");
        ex(0, SErr, 1, "idle_resolve_err", 1);
        ex(0, SPend, 0, "idle_resolve_pend", 1);
        tick();
        idle_a();

        // 5: two-deep branch tracking on B.
        tick();
        if_b.br_issue = 1'b1;
        ex(1, SStall, 0, "b_issue1_stall");
        tick();
        ex(1, SPend, 1, "b_issue2_pend");
        ex(1, SStall, 5'b00011, "b_issue2_stall");
        tick();
        ex(1, SPend, 2, "b_issue3_pend");
        ex(1, SStall, 5'b00011, "b_issue3_stall");
        ex(1, SErr, 0, "b_issue3_err_now");
        ex(1, SErr, 1, "b_issue3_err", 1);
        tick();
        if_b.br_resolve = 1'b1;
        ex(1, SPend, 2, "b_both_pend");
        ex(1, SStall, 5'b00011, "b_both_stall");
        tick();
        if_b.br_issue = 1'b0; if_b.br_resolve = 1'b0;
        ex(1, SPend, 2, "b_both_keep");
        tick();
        if_b.br_resolve = 1'b1;
        ex(1, SStall, 0, "b_res1_stall");
        tick();
        ex(1, SPend, 1, "b_res2_pend");
        ex(1, SStall, 0, "b_res2_stall");
        tick();
        if_b.br_resolve = 1'b0;
        ex(1, SPend, 0, "b_done_pend");
        ex(1, SErr, 1, "b_err_sticky");

        // 6: counter saturation on C (4-bit).
        for (int i = 0; i < 20; i++) begin
            tick();
            if_c.stall_req = 5'b00001;
            ex(2, SCyc, (i < 15) ? i : 15, "c_cycles");
            if (i == 0) begin
                ex(2, SStall, 5'b00001, "c_stall");
                ex(2, SBubble, 5'b00010, "c_bubble");
            end
        end
        tick();
        if_c.stall_req = '0;
        ex(2, SCyc, 15, "c_cycles_sat");
        tick();
        ex(2, SCyc, 15, "c_cycles_hold");
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL expired wait: %0d expectation(s) never compared", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
